// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, drives a 1-cycle synchronous instruction
// memory and buffers returned words with their PC in a small valid/ready queue.
module fetch_queue #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_q,
    input  logic                       redirect,
    input  logic [1:0]                 redirect_sel,
    input  logic [ADDR_W-1:0]          alu_target,
    input  logic [ADDR_W-1:0]          jump_target,
    output logic [DATA_W-1:0]          ir_out,
    output logic [ADDR_W-1:0]          ir_pc,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetchPc;
    logic              reqPending;
    logic [ADDR_W-1:0] reqPc;
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     wrPtr;
    logic [CW-1:0]     count;

    logic [DATA_W-1:0] wordMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];

    logic              validRedirect;
    logic [ADDR_W-1:0] redirectTarget;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       creditUse;

    assign validRedirect  = redirect & ((redirect_sel == 2'b01) | (redirect_sel == 2'b10));
    assign redirectTarget = (redirect_sel == 2'b01) ? alu_target : jump_target;

    assign ir_valid    = (count != '0);
    assign pop         = ir_valid & ir_ready;
    assign push        = reqPending;
    assign ir_out      = ir_valid ? wordMem[rdPtr] : '0;
    assign ir_pc       = ir_valid ? pcMem[rdPtr] : '0;
    assign queue_count = count;
    assign mem_addr    = fetchPc;

    // Credit check: a new read may only be issued if the queue is guaranteed room for
    // it when it returns, counting words already stored and the one still in flight.
    assign creditUse = {1'b0, count} + {{CW{1'b0}}, reqPending} - {{CW{1'b0}}, pop};
    assign issue     = !validRedirect && (creditUse < (CW+1)'(DEPTH));

    // Storage is not reset; entries are only visible through ir_valid-gated outputs.
    always_ff @(posedge CLOCK_50) begin
        if (push && !validRedirect) begin
            wordMem[wrPtr] <= mem_q;
            pcMem[wrPtr]   <= reqPc;
        end
    end

    // A valid redirect flushes everything, including the word returning this cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fetchPc    <= ADDR_W'(RESET_PC);
            reqPending <= 1'b0;
            reqPc      <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
        end else if (validRedirect) begin
            fetchPc    <= redirectTarget;
            reqPending <= 1'b0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
        end else begin
            if (issue) begin
                reqPending <= 1'b1;
                reqPc      <= fetchPc;
                fetchPc    <= fetchPc + 1'b1;
            end else begin
                reqPending <= 1'b0;
            end
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: synchronous ROM returning 16'hA000+addr, streaming,
// stalls, branch/jump redirects, ignored redirect codes and asynchronous reset.
module tb_fetch_queue;

    logic        CLOCK_50;
    logic        reset;
    logic [11:0] mem_addr;
    logic [15:0] mem_q;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic [11:0] alu_target;
    logic [11:0] jump_target;
    logic [15:0] ir_out;
    logic [11:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [1:0]  queue_count;

    int totalChecks = 0;
    int badChecks   = 0;

    fetch_queue #(.ADDR_W(12), .DATA_W(16), .DEPTH(2), .RESET_PC(0)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .redirect    (redirect),
        .redirect_sel(redirect_sel),
        .alu_target  (alu_target),
        .jump_target (jump_target),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .queue_count (queue_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge CLOCK_50) mem_q <= 16'hA000 + {4'h0, mem_addr};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [11:0] pc);
        checkOutput({tag, " valid"}, 32'(ir_valid), 32'd1);
        checkOutput({tag, " pc"}, 32'(ir_pc), 32'(pc));
        checkOutput({tag, " word"}, 32'(ir_out), 32'(16'hA000 + {4'h0, pc}));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, " valid"}, 32'(ir_valid), 32'd0);
        checkOutput({tag, " count"}, 32'(queue_count), 32'd0);
        checkOutput({tag, " word"}, 32'(ir_out), 32'd0);
        checkOutput({tag, " pc"}, 32'(ir_pc), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        redirect     = 1'b0;
        redirect_sel = 2'b00;
        alu_target   = '0;
        jump_target  = '0;
        ir_ready     = 1'b1;
        applyStimulus;
        applyStimulus;
        checkEmpty("reset");
        checkOutput("reset addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;

        // Stream from reset: first word valid after the second edge, then one per cycle.
        applyStimulus;
        checkOutput("edge1 valid", 32'(ir_valid), 32'd0);
        checkOutput("edge1 addr", 32'(mem_addr), 32'd1);
        applyStimulus;
        checkHead("stream0", 12'd0);
        applyStimulus;
        checkHead("stream1", 12'd1);
        applyStimulus;
        checkHead("stream2", 12'd2);
        checkOutput("stream2 count", 32'(queue_count), 32'd1);
        checkOutput("stream2 addr", 32'(mem_addr), 32'd4);

        // Redirect codes 00 and 11 must be ignored.
        redirect = 1'b1; redirect_sel = 2'b00; alu_target = 12'h055; jump_target = 12'h066;
        applyStimulus;
        checkHead("sel00", 12'd3);
        checkOutput("sel00 addr", 32'(mem_addr), 32'd5);
        checkOutput("sel00 count", 32'(queue_count), 32'd1);
        redirect_sel = 2'b11;
        applyStimulus;
        checkHead("sel11", 12'd4);
        checkOutput("sel11 addr", 32'(mem_addr), 32'd6);
        redirect = 1'b0; redirect_sel = 2'b00;
        applyStimulus;
        checkHead("after ignored", 12'd5);

        // Stall mid-stream: queue fills to 2 and fetch stops.
        ir_ready = 1'b0;
        applyStimulus;
        checkHead("stall a", 12'd5);
        checkOutput("stall a count", 32'(queue_count), 32'd2);
        checkOutput("stall a addr", 32'(mem_addr), 32'd7);
        applyStimulus;
        checkHead("stall b", 12'd5);
        checkOutput("stall b addr", 32'(mem_addr), 32'd7);
        ir_ready = 1'b1;
        applyStimulus;
        checkHead("resume6", 12'd6);
        applyStimulus;
        checkHead("resume7", 12'd7);

        // Branch with a read in flight; the accepted head this cycle is flushed.
        redirect = 1'b1; redirect_sel = 2'b01; alu_target = 12'h100; jump_target = 12'h222;
        applyStimulus;
        redirect = 1'b0; redirect_sel = 2'b00;
        checkEmpty("branch N");
        checkOutput("branch N addr", 32'(mem_addr), 32'h100);
        applyStimulus;
        checkOutput("branch N+1 valid", 32'(ir_valid), 32'd0);
        checkOutput("branch N+1 addr", 32'(mem_addr), 32'h101);
        applyStimulus;
        checkHead("branch tgt", 12'h100);
        applyStimulus;
        checkHead("branch tgt+1", 12'h101);

        // Jump to the top of the address space and wrap.
        redirect = 1'b1; redirect_sel = 2'b10; alu_target = 12'h200; jump_target = 12'hFFF;
        applyStimulus;
        redirect = 1'b0; redirect_sel = 2'b00;
        checkEmpty("jump N");
        checkOutput("jump N addr", 32'(mem_addr), 32'hFFF);
        applyStimulus;
        checkOutput("jump wrap addr", 32'(mem_addr), 32'h000);
        applyStimulus;
        checkHead("jump FFF", 12'hFFF);
        applyStimulus;
        checkHead("jump 000", 12'h000);
        applyStimulus;
        checkHead("jump 001", 12'h001);

        // Back-to-back redirects: the last one wins.
        redirect = 1'b1; redirect_sel = 2'b01; alu_target = 12'h100;
        applyStimulus;
        redirect_sel = 2'b10; jump_target = 12'h300;
        applyStimulus;
        redirect = 1'b0; redirect_sel = 2'b00;
        checkEmpty("b2b");
        checkOutput("b2b addr", 32'(mem_addr), 32'h300);
        applyStimulus;
        applyStimulus;
        checkHead("b2b tgt", 12'h300);
        applyStimulus;
        checkHead("b2b tgt+1", 12'h301);

        // Asynchronous reset between edges, then restart with the consumer stalled.
        #3;
        reset = 1'b1;
        #1;
        checkEmpty("async reset");
        checkOutput("async reset addr", 32'(mem_addr), 32'd0);
        ir_ready = 1'b0;
        applyStimulus;
        reset = 1'b0;
        applyStimulus;
        checkOutput("restart edge1 valid", 32'(ir_valid), 32'd0);
        applyStimulus;
        checkHead("restart w0", 12'd0);
        checkOutput("restart count1", 32'(queue_count), 32'd1);
        applyStimulus;
        checkHead("restart full", 12'd0);
        checkOutput("restart count2", 32'(queue_count), 32'd2);
        checkOutput("restart addr", 32'(mem_addr), 32'd2);
        applyStimulus;
        checkOutput("restart hold addr", 32'(mem_addr), 32'd2);
        checkOutput("restart hold word", 32'(ir_out), 32'hA000);
        ir_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus;
            checkHead($sformatf("drain%0d", i), 12'(i));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
